// File: rtl/debug_unit_exec_control.sv
// debug_unit_exec_control: loads instruction memory, gates the pipeline and streams the PC/register dump over UART
module debug_unit_exec_control #(
    parameter int N_BITS       = 8,
    parameter int N_BITS_INSTR = 32,
    parameter int N_BITS_ADDR  = 8,
    parameter int N_REGS       = 32,
    parameter int N_BITS_REG   = 5,
    parameter int NB_STATE     = 3
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable_write_memory,
    input  logic                    i_done_write_memory,
    input  logic [N_BITS_INSTR-1:0] i_data_memory,
    input  logic                    i_execution_mode,
    input  logic                    i_execution_step,
    input  logic                    i_halt,
    input  logic [N_BITS_INSTR-1:0] i_pc,
    input  logic [N_BITS_INSTR-1:0] i_reg_data,
    input  logic                    i_tx_done,
    output logic                    o_imem_write_enable,
    output logic [N_BITS_ADDR-1:0]  o_imem_write_address,
    output logic [N_BITS_INSTR-1:0] o_imem_write_data,
    output logic                    o_pipeline_enable,
    output logic [N_BITS_REG-1:0]   o_reg_read_address,
    output logic                    o_tx_start,
    output logic [N_BITS-1:0]       o_tx_data,
    output logic [NB_STATE-1:0]     o_state
);
    localparam int NB_W = $clog2(N_REGS + 1);
    localparam logic [N_BITS_ADDR-1:0] ADDR_MAX = '1;
    localparam logic [NB_W-1:0] W_LAST = NB_W'(N_REGS);

    typedef enum logic [NB_STATE-1:0] {
        LOAD       = NB_STATE'(0),
        WAIT       = NB_STATE'(1),
        RUN        = NB_STATE'(2),
        STEP       = NB_STATE'(3),
        DUMP_LATCH = NB_STATE'(4),
        DUMP_SEND  = NB_STATE'(5),
        DUMP_WAIT  = NB_STATE'(6),
        DONE       = NB_STATE'(7)
    } state_t;

    state_t                  state_q, state_d;
    logic [N_BITS_ADDR-1:0]  cnt_q, cnt_d, waddr_q, waddr_d;
    logic                    we_q, we_d;
    logic [N_BITS_INSTR-1:0] wdata_q, wdata_d, shift_q, shift_d;
    logic [NB_W-1:0]         w_q, w_d;
    logic [1:0]              byte_q, byte_d;
    logic                    halt_q, halt_d;
    logic                    start_q, start_d;
    logic [N_BITS-1:0]       txd_q, txd_d;

    // state and datapath registers; reset aborts any load or dump in progress
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            shift_q <= '0;
            w_q     <= '0;
            byte_q  <= '0;
            halt_q  <= 1'b0;
            start_q <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            w_q     <= w_d;
            byte_q  <= byte_d;
            halt_q  <= halt_d;
            start_q <= start_d;
            txd_q   <= txd_d;
        end
    end

    // next-state logic; a tx_done coinciding with our own start pulse belongs to nothing and is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        shift_d = shift_q;
        w_d     = w_q;
        byte_d  = byte_q;
        start_d = 1'b0;
        txd_d   = txd_q;
        halt_d  = halt_q | ((state_q == RUN || state_q == STEP) && i_halt);
        case (state_q)
            LOAD: if (i_done_write_memory && i_enable_write_memory) begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = i_data_memory;
                cnt_d   = (cnt_q == ADDR_MAX) ? cnt_q : cnt_q + 1'b1;
                state_d = (&i_data_memory) ? WAIT : LOAD;
            end
            WAIT: state_d = i_execution_mode ? RUN : i_execution_step ? STEP : WAIT;
            RUN: state_d = i_halt ? DUMP_LATCH : RUN;
            STEP: state_d = DUMP_LATCH;
            DUMP_LATCH: begin
                shift_d = (w_q == '0) ? i_pc : i_reg_data;
                byte_d  = '0;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                start_d = 1'b1;
                txd_d   = shift_q[N_BITS_INSTR-1 -: N_BITS];
                state_d = DUMP_WAIT;
            end
            DUMP_WAIT: if (i_tx_done && !start_q) begin
                shift_d = shift_q << N_BITS;
                byte_d  = byte_q + 2'd1;
                if (byte_q != 2'd3) begin
                    state_d = DUMP_SEND;
                end else if (w_q < W_LAST) begin
                    w_d     = w_q + 1'b1;
                    state_d = DUMP_LATCH;
                end else begin
                    w_d     = '0;
                    state_d = halt_q ? DONE : WAIT;
                end
            end
            default: state_d = DONE;
        endcase
    end

    assign o_imem_write_enable  = we_q;
    assign o_imem_write_address = waddr_q;
    assign o_imem_write_data    = wdata_q;
    assign o_pipeline_enable    = (state_q == RUN && !i_halt) || state_q == STEP;
    assign o_reg_read_address   = (w_q == '0) ? '0 : N_BITS_REG'(w_q - 1'b1);
    assign o_tx_start           = start_q;
    assign o_tx_data            = txd_q;
    assign o_state              = state_q;
endmodule

// File: tb/tb_debug_unit_exec_control.sv
// tb_debug_unit_exec_control: directed self-checking bench for debug_unit_exec_control
module tb_debug_unit_exec_control;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_wr = 1'b0, done_wr = 1'b0, mode = 1'b0, step = 1'b0, halt = 1'b0, tx_done = 1'b0;
    logic [31:0] data_mem = '0, pc = '0, reg_data;
    logic        we, pipe_en, tx_start;
    logic [7:0]  waddr, tx_data;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic [2:0]  state;
    logic [31:0] regs [0:31];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    assign reg_data = regs[rd_addr];

    debug_unit_exec_control dut (
        .i_clock(clk), .i_reset(rst),
        .i_enable_write_memory(en_wr), .i_done_write_memory(done_wr), .i_data_memory(data_mem),
        .i_execution_mode(mode), .i_execution_step(step), .i_halt(halt),
        .i_pc(pc), .i_reg_data(reg_data), .i_tx_done(tx_done),
        .o_imem_write_enable(we), .o_imem_write_address(waddr), .o_imem_write_data(wdata),
        .o_pipeline_enable(pipe_en), .o_reg_read_address(rd_addr),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_state(state)
    );

    task automatic load_word(input logic [31:0] w, input logic [7:0] exp_addr, input logic [2:0] exp_state);
        @(negedge clk);
        data_mem = w; done_wr = 1'b1; en_wr = 1'b1;
        @(negedge clk);
        done_wr = 1'b0;
        total++;
        if (we !== 1'b1 || waddr !== exp_addr || wdata !== w || state !== exp_state) begin
            bad++;
            $display("FAIL load_word got we=%b addr=%0d data=%h state=%0d want we=1 addr=%0d data=%h state=%0d",
                     we, waddr, wdata, state, exp_addr, w, exp_state);
        end
        @(negedge clk);
        total++;
        if (we !== 1'b0) begin
            bad++;
            $display("FAIL strobe_len got we=%b want 0", we);
        end
    endtask

    task automatic dump_frame(input logic [31:0] exp_pc, input bit coinc, input bit inject_step, input logic [2:0] exp_final);
        bit          early = 0, en_bad = 0;
        logic [31:0] val;
        logic [7:0]  eb;
        for (int b = 0; b < 132; b++) begin
            int t = 0;
            while (tx_start !== 1'b1 && t < 40) begin
                @(negedge clk);
                if (pipe_en !== 1'b0) en_bad = 1;
                t++;
            end
            if (t >= 40) begin
                total++; bad++;
                $display("FAIL dump_timeout at byte %0d state=%0d", b, state);
                return;
            end
            val = (b < 4) ? exp_pc : regs[b/4 - 1];
            eb  = val[31 - 8*(b%4) -: 8];
            total++;
            if (tx_data !== eb) begin
                bad++;
                $display("FAIL dump_byte %0d got %h want %h", b, tx_data, eb);
            end
            if (coinc && b == 0) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            step = inject_step && b == 5;
            for (int k = 0; k < 3; k++) begin
                if (tx_start !== 1'b0) early = 1;
                if (pipe_en !== 1'b0) en_bad = 1;
                @(negedge clk);
                step = 1'b0;
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL tx_start_before_done got early start=1 want 0");
        end
        total++;
        if (en_bad) begin
            bad++;
            $display("FAIL enable_during_dump got 1 want 0");
        end
        for (int k = 0; k < 4; k++) begin
            if (tx_start !== 1'b0) early = 1;
            @(negedge clk);
        end
        total++;
        if (early || state !== exp_final) begin
            bad++;
            $display("FAIL dump_end got state=%0d extra_start=%b want state=%0d extra_start=0", state, early, exp_final);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (state !== 3'd0 || we !== 0 || waddr !== 0 || wdata !== 0 || pipe_en !== 0 || rd_addr !== 0 || tx_start !== 0 || tx_data !== 0) begin
            bad++;
            $display("FAIL reset_state got state=%0d we=%b addr=%h data=%h en=%b rd=%h start=%b txd=%h want all 0",
                     state, we, waddr, wdata, pipe_en, rd_addr, tx_start, tx_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        load_word(32'h20010005, 8'd0, 3'd0);
        load_word(32'h20020003, 8'd1, 3'd0);
        load_word(32'hFFFFFFFF, 8'd2, 3'd1);
        en_wr = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL load_to_wait got state=%0d want 1", state);
        end
    endtask

    task automatic test_step();
        pc = 32'h00000008;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        total++;
        if (state !== 3'd3 || pipe_en !== 1'b1) begin
            bad++;
            $display("FAIL step_enable got state=%0d en=%b want state=3 en=1", state, pipe_en);
        end
        @(negedge clk);
        total++;
        if (state !== 3'd4 || pipe_en !== 1'b0) begin
            bad++;
            $display("FAIL step_one_cycle got state=%0d en=%b want state=4 en=0", state, pipe_en);
        end
        dump_frame(32'h00000008, 1'b1, 1'b0, 3'd1);
    endtask

    task automatic test_step_during_dump();
        pc = 32'h0000ABCD;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        dump_frame(32'h0000ABCD, 1'b0, 1'b1, 3'd1);
        total++;
        if (pipe_en !== 1'b0) begin
            bad++;
            $display("FAIL step_not_queued got en=%b want 0", pipe_en);
        end
    endtask

    task automatic test_continuous();
        int en_fail = 0;
        pc = 32'hDEADBEEF;
        @(negedge clk);
        mode = 1'b1; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL mode_priority got state=%0d want 2", state);
        end
        for (int i = 0; i < 10; i++) begin
            if (pipe_en !== 1'b1 || state !== 3'd2) en_fail++;
            if (i < 9) @(negedge clk);
        end
        total++;
        if (en_fail != 0) begin
            bad++;
            $display("FAIL run_enable got %0d low cycles want 0", en_fail);
        end
        halt = 1'b1;
        #1;
        total++;
        if (pipe_en !== 1'b0) begin
            bad++;
            $display("FAIL halt_comb_enable got %b want 0", pipe_en);
        end
        @(negedge clk);
        mode = 1'b0;
        total++;
        if (state !== 3'd4) begin
            bad++;
            $display("FAIL halt_to_dump got state=%0d want 4", state);
        end
        halt = 1'b0;
        dump_frame(32'hDEADBEEF, 1'b0, 1'b0, 3'd7);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (state !== 3'd7 || pipe_en !== 1'b0 || tx_start !== 1'b0) begin
            bad++;
            $display("FAIL done_hold got state=%0d en=%b start=%b want state=7 en=0 start=0", state, pipe_en, tx_start);
        end
    endtask

    task automatic test_reset_mid_dump();
        int t = 0;
        bit started = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_word(32'hFFFFFFFF, 8'd0, 3'd1);
        en_wr = 1'b0;
        pc = 32'hAB000000;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        while (tx_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        total++;
        if (state !== 3'd6 || tx_data !== 8'hAB) begin
            bad++;
            $display("FAIL pre_reset_dump got state=%0d txd=%h want state=6 txd=ab", state, tx_data);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || we !== 0 || waddr !== 0 || wdata !== 0 || pipe_en !== 0 || rd_addr !== 0 || tx_start !== 0 || tx_data !== 0) begin
            bad++;
            $display("FAIL async_reset got state=%0d we=%b addr=%h data=%h en=%b rd=%h start=%b txd=%h want all 0",
                     state, we, waddr, wdata, pipe_en, rd_addr, tx_start, tx_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tx_done = (k == 1);
            if (tx_start !== 1'b0) started = 1;
            @(negedge clk);
        end
        tx_done = 1'b0;
        total++;
        if (started || state !== 3'd0) begin
            bad++;
            $display("FAIL post_reset_quiet got state=%0d start_seen=%b want state=0 start_seen=0", state, started);
        end
        load_word(32'h12345678, 8'd0, 3'd0);
        load_word(32'hFFFFFFFF, 8'd1, 3'd1);
        en_wr = 1'b0;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 255; i++) load_word(32'h1000_0000 + i, 8'(i), 3'd0);
        load_word(32'hCAFE0001, 8'd255, 3'd0);
        load_word(32'hCAFE0002, 8'd255, 3'd0);
        load_word(32'hFFFFFFFF, 8'd255, 3'd1);
        en_wr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 | (32'(i) << 12) | 32'(i * 3 + 1);
        regs[0] = 32'h00000000;
        regs[1] = 32'h00000005;
        test_reset();
        test_load();
        test_step();
        test_step_during_dump();
        test_continuous();
        test_reset_mid_dump();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_unit_exec_control.md
Name: debug_unit_exec_control

Overview:
Sequences the MIPS core on behalf of the debug unit. It writes received instruction words into instruction memory and gates the pipeline clock-enable in continuous or single-step mode. After a halt, or after each step, it schedules a register dump (PC plus register file) over the UART transmitter, one byte at a time with a start/done handshake. It sits between the debug receive FSM, the instruction memory write port, the pipeline enable, the register-file debug read port and the UART TX.

Parameters:
N_BITS, 8, UART byte width
N_BITS_INSTR, 32, instruction/register word width
N_BITS_ADDR, 8, instruction memory word-address width
N_REGS, 32, registers dumped after PC
N_BITS_REG, 5, register address width
NB_STATE, 3, state encoding width

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable_write_memory  in  1  receive FSM is in instruction-load phase
i_done_write_memory  in  1  one-cycle pulse: complete word on i_data_memory
i_data_memory  in  N_BITS_INSTR  assembled instruction word
i_execution_mode  in  1  1 = continuous run requested (level)
i_execution_step  in  1  one-cycle step request pulse
i_halt  in  1  halt instruction has reached WB
i_pc  in  N_BITS_INSTR  current PC
i_reg_data  in  N_BITS_INSTR  register file debug read data (asynchronous read)
i_tx_done  in  1  one-cycle pulse: UART byte sent
o_imem_write_enable  out  1  instruction memory write strobe
o_imem_write_address  out  N_BITS_ADDR  word address
o_imem_write_data  out  N_BITS_INSTR  word to write
o_pipeline_enable  out  1  pipeline advance enable
o_reg_read_address  out  N_BITS_REG  register file debug read address
o_tx_start  out  1  one-cycle UART start pulse
o_tx_data  out  N_BITS  byte to send
o_state  out  NB_STATE  current state, for observation

Behaviour:
- Reset (asynchronous): state LOAD; all counters zero; every output 0.
- States: LOAD=0, WAIT=1, RUN=2, STEP=3, DUMP_LATCH=4, DUMP_SEND=5, DUMP_WAIT=6, DONE=7.
- LOAD:
  - On i_done_write_memory && i_enable_write_memory, register o_imem_write_enable=1 for exactly one cycle, with address = word counter and data = i_data_memory.
  - The counter increments after each write.
  - At counter == 2^N_BITS_ADDR-1 the write is performed and the counter saturates. Later writes overwrite the last word.
  - A written word of all ones (halt) moves the FSM to WAIT on the next cycle.
- WAIT:
  - If i_execution_mode=1, go to RUN. This has priority if a step pulse arrives in the same cycle.
  - Otherwise, an i_execution_step pulse goes to STEP.
- RUN: o_pipeline_enable = !i_halt, combinational, so the enable drops in the same cycle halt is seen. When i_halt=1, go to DUMP_LATCH.
- STEP: o_pipeline_enable=1 for exactly one cycle, then DUMP_LATCH.
- Dump frame:
  - word index w runs from 0 to N_REGS. w=0 is i_pc; w=k is register k-1.
  - Total frame = 4*(N_REGS+1) bytes (132 at defaults), each word MSB first.
  - o_reg_read_address = w-1 while w>0, otherwise 0.
- DUMP_LATCH: capture the selected word into a 32-bit shift register and clear the byte counter, then go to DUMP_SEND.
- DUMP_SEND:
  - Register o_tx_start=1 for one cycle, with o_tx_data = shift[31:24]; then go to DUMP_WAIT.
  - o_tx_data holds its value until the next send.
  - An i_tx_done that coincides with the start pulse is ignored.
- DUMP_WAIT: wait for i_tx_done, then shift left by 8 and increment the byte counter.
  - If byte counter < 3, go to DUMP_SEND.
  - Else if w < N_REGS, increment w and go to DUMP_LATCH.
  - Else (frame complete): go to DONE if halt was latched during RUN/STEP; otherwise reset w and go to WAIT.
- DONE: hold, with o_pipeline_enable=0. Leave only by reset.
- i_execution_step pulses outside WAIT are dropped and do not queue.
- o_pipeline_enable is 0 in every state except RUN and STEP.
- The sticky halt flag is set whenever i_halt=1 in RUN or STEP.
- Reset mid-dump or mid-load aborts immediately. No partial byte is emitted after reset.

Test Plan:
- Load 3 words (0x20010005, 0x20020003, 0xFFFFFFFF) via done pulses → writes at addresses 0, 1, 2, each strobe 1 cycle; state goes to WAIT after the third word.
- Step mode: one i_execution_step → exactly one o_pipeline_enable cycle, then 132 o_tx_start pulses (PC bytes first), each only after the prior i_tx_done; return to WAIT.
- Send i_pc=0x00000008 and reg r1=0x00000005 → first 8 tx bytes are 00 00 00 08 00 00 00 00 (r0), then bytes 9-12 are 00 00 00 05 (r1).
- Continuous mode: assert i_execution_mode and raise i_halt after 10 cycles → enable is high for 10 cycles and low in the halt cycle; a full dump follows; final state is DONE; later steps are ignored.
- Step pulse during a dump → ignored: no extra enable cycle, byte count unchanged.
- Assert i_reset asynchronously during DUMP_WAIT → all outputs 0 immediately, state LOAD; a new load restarts at address 0.
